truth_table_sweeper: RTL
========================

// Module: truth_table_sweeper
// PURPOSE
//   Drives a combinational function under test (FUT) with every input combination in
//   ascending binary order. Waits a fixed number of settle cycles per combination, then
//   samples the FUT output into a truth-table register.
//   Sits directly upstream of the FUT, feeding its inputs (e.g. {x,y}), and directly
//   downstream of it, consuming its output s.
//   Replaces hand-written #1 stimulus sequences with a clocked, self-timed sweep.
// PARAMETERS
//   N_IN    2   number of FUT inputs; legal range 1..4; table width is 2**N_IN
//   SETTLE  1   clock cycles each combination is held before sampling; legal >= 1
// PORTS
//   clk        in   1          rising-edge clock
//   rst_n      in   1          asynchronous active-low reset
//   start      in   1          request a sweep; sampled only in IDLE
//   fut_s      in   1          FUT output
//   fut_in     out  N_IN       FUT input vector; MSB = first operand (x), LSB = last (y)
//   table_out  out  2**N_IN    table_out[i] = FUT output for fut_in == i
//   busy       out  1          high while a sweep is in progress
//   done       out  1          one-cycle pulse when the sweep completes
//   expected   in   2**N_IN    golden table             (only with TT_CHECK_EN)
//   mismatch   out  1          table_out != expected    (only with TT_CHECK_EN)
// BEHAVIOUR
//   - Reset (rst_n low, takes effect immediately):
//     state=IDLE; fut_in, table_out, busy, done, mismatch = 0; index and settle counter = 0.
//   - FSM: two states, IDLE and RUN. All outputs are registered.
//   - IDLE, start=1 at edge k:
//     -> RUN; busy<=1; fut_in<=0; table_out<=0; settle cnt<=SETTLE-1; done<=0.
//   - RUN, settle cnt != 0: decrement the counter; fut_in is held.
//   - RUN, settle cnt == 0: table_out[fut_in] <= fut_s.
//     - If fut_in != 2**N_IN-1: fut_in<=fut_in+1; cnt<=SETTLE-1.
//     - Else: state<=IDLE; busy<=0; done<=1; fut_in<=0.
//   - Timing: sample for index i occurs at edge k+(i+1)*SETTLE.
//     done is high for exactly the cycle after edge k+2**N_IN*SETTLE.
//     Defaults: 4 cycles from start to done.
//   - done clears on the next edge unconditionally. A start in the done cycle is accepted,
//     giving back-to-back sweeps.
//   - start while busy is ignored (no restart, no queueing).
//   - table_out holds its value in IDLE until the next accepted start clears it.
//   - The index never wraps: fut_in returns to 0 only via completion or reset.
//   - Reset mid-sweep aborts the sweep: no done pulse, and the partial table is discarded (0).
//   - Sampling occurs on the edge that advances fut_in, so the FUT sees each value for
//     exactly SETTLE cycles.
// CONFIGURATION
//   TT_CHECK_EN defined:
//     - Adds ports expected and mismatch.
//     - At the completion edge, mismatch <= (final table != expected). The compare uses the
//       bit being sampled on that edge.
//     - mismatch holds until the next accepted start (cleared to 0) or reset.
//   TT_CHECK_EN undefined:
//     - Ports expected and mismatch are absent; no compare logic is present.
//     - All other behaviour is identical.
// TESTING
//   1. FUT = nand(xor(x,y), nor(~x,~y)), defaults, pulse start
//      -> fut_in 00,01,10,11 on successive cycles; done after 4 cycles; table_out=4'b1111.
//   2. FUT = x^y, defaults -> table_out=4'b0110, done pulse width exactly 1 cycle,
//      busy high for 4 cycles.
//   3. SETTLE=3, FUT = x&y -> each fut_in value held 3 cycles; done 12 cycles after start;
//      table_out=4'b1000.
//   4. start held high throughout -> start during RUN ignored; a new sweep begins in the
//      done cycle; table_out is cleared to 0 on re-accept.
//   5. rst_n low for 1 cycle during index 2
//      -> all outputs 0 immediately, no done pulse, IDLE; a next start sweeps cleanly.
//   6. TT_CHECK_EN, expected=4'b1000, FUT = the item-1 function -> mismatch=1 at done;
//      with expected=4'b1111 -> mismatch=0.

Source files
------------

// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper
//   Drives a combinational function under test (FUT) with every input combination in
//   ascending binary order. Each combination is held for SETTLE cycles. The FUT output is
//   then sampled into a truth-table register, on the same edge that advances the index.
//
//   Optional feature macro: TT_CHECK_EN
//     When defined, the block compares the finished table against a golden table.
//
// Parameters
//   N_IN    number of FUT inputs (1..4); the table is 2**N_IN bits wide
//   SETTLE  cycles each combination is held before it is sampled (>= 1)
//
// Ports
//   clk_i         rising-edge clock
//   rst_ni        asynchronous active-low reset
//   start_i       sweep request; sampled only in idle
//   fut_s_i       FUT output
//   fut_in_o      FUT input vector (MSB = first operand)
//   table_out_o   table_out_o[i] = FUT output observed for fut_in_o == i
//   expected_i    golden table                        (TT_CHECK_EN only)
//   mismatch_o    final table differs from expected_i (TT_CHECK_EN only)
//   busy_o        sweep in progress
//   done_o        one-cycle pulse on sweep completion
module truth_table_sweeper #(
  parameter int unsigned N_IN   = 2,
  parameter int unsigned SETTLE = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   start_i,
  input  logic                   fut_s_i,
  output logic [N_IN-1:0]        fut_in_o,
  output logic [(1<<N_IN)-1:0]   table_out_o,
`ifdef TT_CHECK_EN
  input  logic [(1<<N_IN)-1:0]   expected_i,
  output logic                   mismatch_o,
`endif
  output logic                   busy_o,
  output logic                   done_o
);

  localparam int unsigned Width = 1 << N_IN;
  localparam int unsigned CntW  = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CntW-1:0] CntInit = CntW'(SETTLE - 1);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e            state_q, state_d;
  logic [N_IN-1:0]   fut_in_q, fut_in_d;
  logic [Width-1:0]  table_q, table_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
`ifdef TT_CHECK_EN
  logic              mismatch_q, mismatch_d;
`endif

  always_comb begin
    state_d  = state_q;
    fut_in_d = fut_in_q;
    table_d  = table_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;  // done is a single-cycle pulse
`ifdef TT_CHECK_EN
    mismatch_d = mismatch_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d  = StRun;
          busy_d   = 1'b1;
          fut_in_d = '0;
          table_d  = '0;
          cnt_d    = CntInit;
`ifdef TT_CHECK_EN
          mismatch_d = 1'b0;
`endif
        end
      end
      StRun: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CntW'(1);
        end else begin
          table_d[fut_in_q] = fut_s_i;
          if (fut_in_q != '1) begin
            fut_in_d = fut_in_q + N_IN'(1);
            cnt_d    = CntInit;
          end else begin
            state_d  = StIdle;
            busy_d   = 1'b0;
            done_d   = 1'b1;
            fut_in_d = '0;
`ifdef TT_CHECK_EN
            // table_d already holds the bit sampled on this edge.
            mismatch_d = (table_d != expected_i);
`endif
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      fut_in_q <= '0;
      table_q  <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef TT_CHECK_EN
      mismatch_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      fut_in_q <= fut_in_d;
      table_q  <= table_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef TT_CHECK_EN
      mismatch_q <= mismatch_d;
`endif
    end
  end

  assign fut_in_o    = fut_in_q;
  assign table_out_o = table_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
`ifdef TT_CHECK_EN
  assign mismatch_o  = mismatch_q;
`endif

endmodule
